// File: rtl/vrf_read_pkg.sv
// vrf_read_pkg: shared request struct and field widths for the VRF read pipe.
package vrf_read_pkg;
  localparam int VS_W      = 5;
  localparam int OFF_W     = 5;
  localparam int SRC_W     = 2;
  localparam int ENQ_SRC_W = 4;
  localparam int IDX_W     = 3;
  typedef struct packed {
    logic [VS_W-1:0]  vs;
    logic [OFF_W-1:0] offset;
    logic [SRC_W-1:0] read_source;
    logic [IDX_W-1:0] instruction_index;
  } vrf_req_t;
endpackage

// File: rtl/vrf_read_data_queue.sv
// vrf_read_data_queue: per-channel read-data FIFO, no empty bypass, reports occupancy.
module vrf_read_data_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [DATA_W-1:0]        deq_bits,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pop, wr;
  always_comb begin
    pop = deq_ready && cnt_q != '0;
    wr = push && (int'(cnt_q) != DEPTH || pop);
    overflow = push && !wr;
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(wr) - CW'(pop);
    deq_valid = cnt_q != '0;
    deq_bits = mem_q[rp_q];
    count = cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (wr) mem_q[wp_q] <= push_data;
  end
endmodule

// File: rtl/vrf_read_pipe_mc.sv
// vrf_read_pipe_mc: credit-based round-robin VRF read arbiter with fixed-latency return pipe
// and per-channel data queues.
module vrf_read_pipe_mc
  import vrf_read_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enq_valid,
  output logic [NUM_CH-1:0]           enq_ready,
  input  logic [VS_W*NUM_CH-1:0]      enq_vs,
  input  logic [OFF_W*NUM_CH-1:0]     enq_offset,
  input  logic [ENQ_SRC_W*NUM_CH-1:0] enq_read_source,
  input  logic [IDX_W*NUM_CH-1:0]     enq_instruction_index,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [VS_W-1:0]             req_vs,
  output logic [OFF_W-1:0]            req_offset,
  output logic [SRC_W-1:0]            req_read_source,
  output logic [IDX_W-1:0]            req_instruction_index,
  input  logic [DATA_W-1:0]           vrf_rd_result,
  output logic [NUM_CH-1:0]           deq_valid,
  input  logic [NUM_CH-1:0]           deq_ready,
  output logic [DATA_W*NUM_CH-1:0]    deq_bits,
  output logic                        overflow_err
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  vrf_req_t reqs [NUM_CH];
  vrf_req_t req;
  logic [NUM_CH-1:0] elig, ovf;
  logic [CW-1:0] occ [NUM_CH];
  logic [CW-1:0] inf_q [NUM_CH];
  logic [CW-1:0] inf_d [NUM_CH];
  logic [CH_W-1:0] rr_q, rr_d, gnt;
  logic [LATENCY-1:0] pv_q, pv_d;
  logic [CH_W-1:0] pid_q [LATENCY];
  logic [CH_W-1:0] pid_d [LATENCY];
  logic fire, pipe_out, overflow_err_q, overflow_err_d, src_unused;
  int best;
  assign src_unused = ^enq_read_source;
  // rr_q holds the first channel to search; a channel needs a free slot counting in-flight reads
  always_comb begin
    best = NUM_CH;
    gnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      reqs[c] = '{vs: enq_vs[c*VS_W +: VS_W], offset: enq_offset[c*OFF_W +: OFF_W],
                  read_source: enq_read_source[c*ENQ_SRC_W +: SRC_W],
                  instruction_index: enq_instruction_index[c*IDX_W +: IDX_W]};
      elig[c] = enq_valid[c] && (int'(occ[c]) + int'(inf_q[c]) < DEPTH);
      if (elig[c] && (c + NUM_CH - int'(rr_q)) % NUM_CH < best) begin
        best = (c + NUM_CH - int'(rr_q)) % NUM_CH;
        gnt = CH_W'(c);
      end
    end
    req = reqs[gnt];
    req_valid = |elig;
    fire = req_valid && req_ready;
    for (int c = 0; c < NUM_CH; c++) enq_ready[c] = req_ready && elig[c] && gnt == CH_W'(c);
    rr_d = fire ? (int'(gnt) == NUM_CH - 1 ? '0 : gnt + CH_W'(1)) : rr_q;
  end
  assign req_vs = req.vs;
  assign req_offset = req.offset;
  assign req_read_source = req.read_source;
  assign req_instruction_index = req.instruction_index;
  always_comb begin
    pv_d[0] = fire;
    pid_d[0] = gnt;
    for (int s = 1; s < LATENCY; s++) begin
      pv_d[s] = pv_q[s-1];
      pid_d[s] = pid_q[s-1];
    end
    pipe_out = pv_q[LATENCY-1];
    for (int c = 0; c < NUM_CH; c++)
      inf_d[c] = inf_q[c] + CW'(fire && gnt == CH_W'(c))
                 - CW'(pipe_out && pid_q[LATENCY-1] == CH_W'(c));
    overflow_err_d = overflow_err_q || |ovf;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pv_q <= '0;
      rr_q <= '0;
      inf_q <= '{default: '0};
      overflow_err_q <= 1'b0;
    end else begin
      pv_q <= pv_d;
      rr_q <= rr_d;
      inf_q <= inf_d;
      overflow_err_q <= overflow_err_d;
    end
    pid_q <= pid_d;
  end
  assign overflow_err = overflow_err_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_q
    vrf_read_data_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_q (
      .clock     (clock),
      .reset     (reset),
      .push      (pipe_out && pid_q[LATENCY-1] == CH_W'(g)),
      .push_data (vrf_rd_result),
      .deq_valid (deq_valid[g]),
      .deq_ready (deq_ready[g]),
      .deq_bits  (deq_bits[g*DATA_W +: DATA_W]),
      .count     (occ[g]),
      .overflow  (ovf[g])
    );
  end
endmodule
